// File: rtl/multi_dataflow_engine_pkg.sv
// Shared types for the multi_dataflow engine: control/flag records exchanged with the
// control FSM, plus the engine state encoding and beat-counter width.
package multi_dataflow_engine_pkg;

    localparam int unsigned CNT_LEN = 1024;
    localparam int unsigned CNT_W   = $clog2(CNT_LEN) + 1;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} engine_state_t;

    typedef struct packed {
        logic             clear;
        logic             enable;
        logic             start;
        logic [CNT_W-1:0] cnt_limit_outStream0;
        logic [31:0]      reg_simple_mul;
        logic [31:0]      reg_shift;
        logic [31:0]      reg_len;
        logic [31:0]      configuration;
    } ctrl_engine_t;

    typedef struct packed {
        logic [CNT_W-1:0] cnt_outStream0;
        logic             done;
        logic             ready;
    } flags_engine_t;

endpackage

// File: rtl/multi_dataflow_engine_ctrl.sv
// Engine sequencer: kernel start handshake, outStream0 beat counter and the kernel
// config latch. Stream gating lives in the top.
module multi_dataflow_engine_ctrl
    import multi_dataflow_engine_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  ctrl_engine_t  ctrl_i,
    input  logic          beat_i,
    input  logic          k_ready_i,
    output engine_state_t state_o,
    output flags_engine_t flags_o,
    output logic          k_start_o,
    output logic [31:0]   k_reg_simple_mul_o,
    output logic [31:0]   k_reg_shift_o,
    output logic [31:0]   k_reg_len_o,
    output logic [31:0]   k_config_o
);

    engine_state_t    state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] limit_d, limit_q;
    logic [31:0]      mul_d, mul_q, shift_d, shift_q, len_d, len_q, cfg_d, cfg_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        mul_d   = mul_q;
        shift_d = shift_q;
        len_d   = len_q;
        cfg_d   = cfg_q;
        // clear wins over everything; enable=0 freezes the sequencer
        if (ctrl_i.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (ctrl_i.enable) begin
            unique case (state_q)
                IDLE: begin
                    if (ctrl_i.start) begin
                        limit_d = ctrl_i.cnt_limit_outStream0;
                        mul_d   = ctrl_i.reg_simple_mul;
                        shift_d = ctrl_i.reg_shift;
                        len_d   = ctrl_i.reg_len;
                        cfg_d   = ctrl_i.configuration;
                        cnt_d   = '0;
                        state_d = (ctrl_i.cnt_limit_outStream0 == '0) ? DONE : START;
                    end
                end
                START: begin
                    if (k_ready_i) state_d = RUN;
                end
                RUN: begin
                    if (beat_i) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == limit_q) state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            limit_q <= '0;
            mul_q   <= '0;
            shift_q <= '0;
            len_q   <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            mul_q   <= mul_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            cfg_q   <= cfg_d;
        end
    end

    assign state_o                = state_q;
    assign k_start_o              = (state_q == START);
    assign flags_o.cnt_outStream0 = cnt_q;
    assign flags_o.done           = (state_q == DONE);
    assign flags_o.ready          = (state_q == IDLE);
    assign k_reg_simple_mul_o     = mul_q;
    assign k_reg_shift_o          = shift_q;
    assign k_reg_len_o            = len_q;
    assign k_config_o             = cfg_q;

endmodule

// File: rtl/multi_dataflow_engine.sv
// Datapath-side engine of the multi_dataflow HWPE: gates the three input streams and the
// kernel output stream while a job is active, and hosts the sequencer.
module multi_dataflow_engine
    import multi_dataflow_engine_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  ctrl_engine_t          ctrl_i,
    output flags_engine_t         flags_o,
    input  logic                  inStream0_valid_i,
    input  logic [DATA_WIDTH-1:0] inStream0_data_i,
    output logic                  inStream0_ready_o,
    input  logic                  inStream1_valid_i,
    input  logic [DATA_WIDTH-1:0] inStream1_data_i,
    output logic                  inStream1_ready_o,
    input  logic                  inStream2_valid_i,
    input  logic [DATA_WIDTH-1:0] inStream2_data_i,
    output logic                  inStream2_ready_o,
    output logic                  k_in0_valid_o,
    output logic [DATA_WIDTH-1:0] k_in0_data_o,
    input  logic                  k_in0_ready_i,
    output logic                  k_in1_valid_o,
    output logic [DATA_WIDTH-1:0] k_in1_data_o,
    input  logic                  k_in1_ready_i,
    output logic                  k_in2_valid_o,
    output logic [DATA_WIDTH-1:0] k_in2_data_o,
    input  logic                  k_in2_ready_i,
    input  logic                  k_out_valid_i,
    input  logic [DATA_WIDTH-1:0] k_out_data_i,
    output logic                  k_out_ready_o,
    output logic                  outStream0_valid_o,
    output logic [DATA_WIDTH-1:0] outStream0_data_o,
    input  logic                  outStream0_ready_i,
    output logic                  k_start_o,
    input  logic                  k_done_i,
    input  logic                  k_idle_i,
    input  logic                  k_ready_i,
    output logic [31:0]           k_reg_simple_mul_o,
    output logic [31:0]           k_reg_shift_o,
    output logic [31:0]           k_reg_len_o,
    output logic [31:0]           k_config_o
);

    engine_state_t state;
    logic          gate;
    logic          beat;
    // Kernel done/idle are status only; completion is decided by the beat count.
    logic          unused_status;

    assign unused_status = k_done_i ^ k_idle_i;
    assign gate = ctrl_i.enable & ((state == START) | (state == RUN));

    assign inStream0_ready_o  = k_in0_ready_i & gate;
    assign inStream1_ready_o  = k_in1_ready_i & gate;
    assign inStream2_ready_o  = k_in2_ready_i & gate;
    assign k_in0_valid_o      = inStream0_valid_i & gate;
    assign k_in1_valid_o      = inStream1_valid_i & gate;
    assign k_in2_valid_o      = inStream2_valid_i & gate;
    assign k_in0_data_o       = inStream0_data_i;
    assign k_in1_data_o       = inStream1_data_i;
    assign k_in2_data_o       = inStream2_data_i;
    assign outStream0_valid_o = k_out_valid_i & gate;
    assign k_out_ready_o      = outStream0_ready_i & gate;
    assign outStream0_data_o  = k_out_data_i;
    assign beat               = outStream0_valid_o & outStream0_ready_i;

    multi_dataflow_engine_ctrl u_ctrl (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .ctrl_i             (ctrl_i),
        .beat_i             (beat),
        .k_ready_i          (k_ready_i),
        .state_o            (state),
        .flags_o            (flags_o),
        .k_start_o          (k_start_o),
        .k_reg_simple_mul_o (k_reg_simple_mul_o),
        .k_reg_shift_o      (k_reg_shift_o),
        .k_reg_len_o        (k_reg_len_o),
        .k_config_o         (k_config_o)
    );

endmodule

// File: tb/tb_multi_dataflow_engine.sv
// Bench for multi_dataflow_engine: scripted job sequences, a gating vector table and a
// scoreboard on the outStream0 data path.
module tb_multi_dataflow_engine;
    import multi_dataflow_engine_pkg::*;

    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    ctrl_engine_t  ctrl_i;
    flags_engine_t flags_o;
    logic [2:0]    in_valid, in_ready_o, k_in_valid_o, k_in_ready;
    logic [DW-1:0] in_data [3];
    logic [DW-1:0] k_in_data [3];
    logic          k_out_valid, k_out_ready_o, out_valid_o, out_ready;
    logic [DW-1:0] k_out_data, out_data_o;
    logic          k_start_o, k_done, k_idle, k_ready;
    logic [31:0]   k_mul_o, k_shift_o, k_len_o, k_cfg_o;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] sb_q [$];

    typedef struct {
        logic       en;
        logic [2:0] iv;
        logic [2:0] kr;
        logic [2:0] exp_ir;
        logic [2:0] exp_kv;
    } vec_t;
    vec_t vecs [6];

    always #5 clk_i = ~clk_i;

    multi_dataflow_engine #(.DATA_WIDTH(DW)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .ctrl_i             (ctrl_i),
        .flags_o            (flags_o),
        .inStream0_valid_i  (in_valid[0]),
        .inStream0_data_i   (in_data[0]),
        .inStream0_ready_o  (in_ready_o[0]),
        .inStream1_valid_i  (in_valid[1]),
        .inStream1_data_i   (in_data[1]),
        .inStream1_ready_o  (in_ready_o[1]),
        .inStream2_valid_i  (in_valid[2]),
        .inStream2_data_i   (in_data[2]),
        .inStream2_ready_o  (in_ready_o[2]),
        .k_in0_valid_o      (k_in_valid_o[0]),
        .k_in0_data_o       (k_in_data[0]),
        .k_in0_ready_i      (k_in_ready[0]),
        .k_in1_valid_o      (k_in_valid_o[1]),
        .k_in1_data_o       (k_in_data[1]),
        .k_in1_ready_i      (k_in_ready[1]),
        .k_in2_valid_o      (k_in_valid_o[2]),
        .k_in2_data_o       (k_in_data[2]),
        .k_in2_ready_i      (k_in_ready[2]),
        .k_out_valid_i      (k_out_valid),
        .k_out_data_i       (k_out_data),
        .k_out_ready_o      (k_out_ready_o),
        .outStream0_valid_o (out_valid_o),
        .outStream0_data_o  (out_data_o),
        .outStream0_ready_i (out_ready),
        .k_start_o          (k_start_o),
        .k_done_i           (k_done),
        .k_idle_i           (k_idle),
        .k_ready_i          (k_ready),
        .k_reg_simple_mul_o (k_mul_o),
        .k_reg_shift_o      (k_shift_o),
        .k_reg_len_o        (k_len_o),
        .k_config_o         (k_cfg_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive the kernel output side; 'open' says whether the gate should be open now.
    task automatic drive_out(input logic v, input logic r, input logic [DW-1:0] d,
                             input logic open);
        k_out_valid = v;
        out_ready   = r;
        k_out_data  = d;
        if (v && r && open) sb_q.push_back(d);
        #1;
        check("out_valid", {31'd0, out_valid_o}, {31'd0, v & open});
        check("k_out_ready", {31'd0, k_out_ready_o}, {31'd0, r & open});
        if (out_valid_o && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got beat 0x%0h want no beat", out_data_o);
            end else begin
                check("out_data", out_data_o, sb_q.pop_front());
            end
        end
    endtask

    task automatic chk_flags(input string tag, input int cnt, input logic done,
                             input logic rdy, input logic kst);
        check({tag, "_cnt"}, {21'd0, flags_o.cnt_outStream0}, cnt);
        check({tag, "_done"}, {31'd0, flags_o.done}, {31'd0, done});
        check({tag, "_ready"}, {31'd0, flags_o.ready}, {31'd0, rdy});
        check({tag, "_kstart"}, {31'd0, k_start_o}, {31'd0, kst});
    endtask

    task automatic issue_start(input int limit, input logic [31:0] shift, input logic [31:0] len);
        ctrl_i.start                = 1'b1;
        ctrl_i.cnt_limit_outStream0 = limit[CNT_W-1:0];
        ctrl_i.reg_shift            = shift;
        ctrl_i.reg_len              = len;
        ctrl_i.reg_simple_mul       = 32'h11;
        ctrl_i.configuration        = 32'hC0;
        tick();
        ctrl_i.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 3'b111, 3'b111, 3'b111, 3'b111};
        vecs[1] = '{1'b1, 3'b101, 3'b010, 3'b010, 3'b101};
        vecs[2] = '{1'b1, 3'b000, 3'b111, 3'b111, 3'b000};
        vecs[3] = '{1'b0, 3'b111, 3'b111, 3'b000, 3'b000};
        vecs[4] = '{1'b1, 3'b011, 3'b110, 3'b110, 3'b011};
        vecs[5] = '{1'b0, 3'b100, 3'b001, 3'b000, 3'b000};

        ctrl_i = '0;
        ctrl_i.enable = 1'b1;
        rst_i = 1'b1;
        in_valid = '0;
        k_in_ready = '0;
        k_out_valid = 1'b0;
        out_ready = 1'b0;
        k_out_data = '0;
        k_ready = 1'b0;
        k_done = 1'b0;
        k_idle = 1'b1;
        for (int i = 0; i < 3; i++) in_data[i] = 32'h1000_0000 * (i + 1);
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state, with every upstream handshake asserted
        in_valid = 3'b111;
        k_in_ready = 3'b111;
        drive_out(1'b1, 1'b1, 32'hDEAD, 1'b0);
        chk_flags("rst", 0, 1'b0, 1'b1, 1'b0);
        check("rst_shift", k_shift_o, 32'h0);
        check("rst_cfg", k_cfg_o, 32'h0);
        check("rst_in_ready", {29'd0, in_ready_o}, 32'h0);
        check("rst_k_in_valid", {29'd0, k_in_valid_o}, 32'h0);
        in_valid = '0;
        k_in_ready = '0;
        k_out_valid = 1'b0;

        // Job 1: limit 4, kernel ready on the third START cycle
        issue_start(4, 32'h3, 32'h4);
        for (int c = 1; c <= 3; c++) begin
            k_ready = (c == 3);
            #1;
            chk_flags("j1_start", 0, 1'b0, 1'b0, 1'b1);
            if (c == 1) begin
                check("j1_shift", k_shift_o, 32'h3);
                check("j1_mul", k_mul_o, 32'h11);
            end
            tick();
        end
        k_ready = 1'b0;
        for (int b = 1; b <= 4; b++) begin
            drive_out(1'b1, 1'b1, 32'hA000_0000 + b, 1'b1);
            chk_flags("j1_run", b - 1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive_out(1'b1, 1'b1, 32'hBAD0, 1'b0);
        chk_flags("j1_done", 4, 1'b1, 1'b0, 1'b0);
        tick();
        drive_out(1'b0, 1'b1, 32'h0, 1'b0);
        chk_flags("j1_idle", 4, 1'b0, 1'b1, 1'b0);

        // Job 2: limit 3, sink ready toggles
        issue_start(3, 32'h1, 32'h3);
        k_ready = 1'b1;
        #1;
        check("j2_kstart", {31'd0, k_start_o}, 32'h1);
        tick();
        k_ready = 1'b0;
        begin
            logic r_pat [5];
            int   exp_cnt [5];
            r_pat   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            exp_cnt = '{1, 1, 2, 2, 3};
            for (int i = 0; i < 5; i++) begin
                drive_out(1'b1, r_pat[i], 32'hB000_0000 + i, 1'b1);
                tick();
                check("j2_cnt", {21'd0, flags_o.cnt_outStream0}, exp_cnt[i]);
            end
        end
        drive_out(1'b1, 1'b1, 32'hB0FF, 1'b0);
        chk_flags("j2_done", 3, 1'b1, 1'b0, 1'b0);
        tick();
        drive_out(1'b1, 1'b1, 32'hB0FE, 1'b0);
        chk_flags("j2_idle", 3, 1'b0, 1'b1, 1'b0);
        k_out_valid = 1'b0;

        // Job 3: zero-length job
        issue_start(0, 32'h2, 32'h0);
        #1;
        chk_flags("j3_done", 0, 1'b1, 1'b0, 1'b0);
        tick();
        #1;
        chk_flags("j3_idle", 0, 1'b0, 1'b1, 1'b0);

        // Job 4: enable stall in START, gating table, enable stall in RUN, clear at cnt 7
        issue_start(10, 32'h4, 32'h44);
        ctrl_i.enable = 1'b0;
        k_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("j4_start_hold", {31'd0, k_start_o}, 32'h1);
            tick();
        end
        ctrl_i.enable = 1'b1;
        tick();
        k_ready = 1'b0;
        #1;
        check("j4_run_kstart", {31'd0, k_start_o}, 32'h0);
        for (int b = 1; b <= 2; b++) begin
            drive_out(1'b1, 1'b1, 32'hC000_0000 + b, 1'b1);
            tick();
        end
        k_out_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ctrl_i.enable = vecs[i].en;
            in_valid = vecs[i].iv;
            k_in_ready = vecs[i].kr;
            for (int s = 0; s < 3; s++) in_data[s] = $urandom;
            drive_out(1'b0, 1'b1, 32'h0, vecs[i].en);
            check("tbl_in_ready", {29'd0, in_ready_o}, {29'd0, vecs[i].exp_ir});
            check("tbl_k_in_valid", {29'd0, k_in_valid_o}, {29'd0, vecs[i].exp_kv});
            for (int s = 0; s < 3; s++) check("tbl_data", k_in_data[s], in_data[s]);
            tick();
        end
        check("tbl_cnt", {21'd0, flags_o.cnt_outStream0}, 32'd2);
        ctrl_i.enable = 1'b0;
        in_valid = 3'b111;
        k_in_ready = 3'b111;
        for (int c = 0; c < 5; c++) begin
            drive_out(1'b1, 1'b1, 32'hD000_0000 + c, 1'b0);
            check("stall_in_ready", {29'd0, in_ready_o}, 32'h0);
            check("stall_k_in_valid", {29'd0, k_in_valid_o}, 32'h0);
            tick();
            chk_flags("stall", 2, 1'b0, 1'b0, 1'b0);
        end
        ctrl_i.enable = 1'b1;
        for (int b = 3; b <= 7; b++) begin
            drive_out(1'b1, 1'b1, 32'hE000_0000 + b, 1'b1);
            tick();
            check("resume_cnt", {21'd0, flags_o.cnt_outStream0}, b);
        end
        k_out_valid = 1'b0;
        ctrl_i.clear = 1'b1;
        ctrl_i.start = 1'b1;
        ctrl_i.reg_len = 32'h55;
        tick();
        ctrl_i.clear = 1'b0;
        ctrl_i.start = 1'b0;
        #1;
        chk_flags("clr", 0, 1'b0, 1'b1, 1'b0);
        check("clr_in_ready", {29'd0, in_ready_o}, 32'h0);
        check("clr_len_hold", k_len_o, 32'h44);
        tick();
        chk_flags("clr_after", 0, 1'b0, 1'b1, 1'b0);
        in_valid = '0;
        k_in_ready = '0;

        // Job 5: start during RUN is ignored, then a fresh start relatches config
        issue_start(2, 32'h9, 32'h11);
        k_ready = 1'b1;
        tick();
        k_ready = 1'b0;
        ctrl_i.start = 1'b1;
        ctrl_i.cnt_limit_outStream0 = 5;
        ctrl_i.reg_shift = 32'hA;
        drive_out(1'b1, 1'b1, 32'hF000_0001, 1'b1);
        tick();
        ctrl_i.start = 1'b0;
        check("j5_shift_kept", k_shift_o, 32'h9);
        chk_flags("j5_run", 1, 1'b0, 1'b0, 1'b0);
        drive_out(1'b1, 1'b1, 32'hF000_0002, 1'b1);
        tick();
        k_out_valid = 1'b0;
        chk_flags("j5_done", 2, 1'b1, 1'b0, 1'b0);
        tick();
        issue_start(3, 32'h5, 32'h3);
        check("j6_shift", k_shift_o, 32'h5);
        chk_flags("j6_start", 0, 1'b0, 1'b0, 1'b1);

        // Reset in mid-RUN
        k_ready = 1'b1;
        tick();
        k_ready = 1'b0;
        drive_out(1'b1, 1'b1, 32'hF100_0001, 1'b1);
        tick();
        k_out_valid = 1'b0;
        check("j6_cnt", {21'd0, flags_o.cnt_outStream0}, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk_flags("mid_rst", 0, 1'b0, 1'b1, 1'b0);
        check("mid_rst_shift", k_shift_o, 32'h0);
        tick();
        chk_flags("mid_rst_after", 0, 1'b0, 1'b1, 1'b0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
